// File: rtl/ram_arb_pkg.sv
// ram_arbiter shared types.
// FSM encoding, requester count, one-hot helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    DATA,
    WR
  } ram_arb_state_t;

  localparam int NUM_REQ = 2;

  function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of ram_arbiter.
// Two request channels plus a shared response.
interface ram_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
);
  import ram_arb_pkg::*;

  localparam int NB = WIDTH / 8;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_we;
  logic [NUM_REQ-1:0][AW-1:0]  req_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0][NB-1:0]  req_wstrb;
  logic [NUM_REQ-1:0]          resp_valid;
  logic                        resp_err;
  logic [WIDTH-1:0]            resp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wstrb,
    input  req_ready, resp_valid,
    input  resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wstrb,
    output req_ready, resp_valid,
    output resp_err, resp_rdata
  );

endinterface

// File: rtl/rr_grant2.sv
// Two-way round-robin picker.
// On contention the requester not served last wins.
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  assign any   = |valid;
  assign grant = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer for one block_ram.
// Partial stores run as read-modify-write.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int SIZE  = 4096,
  parameter  int WIDTH = 32,
  localparam int NB    = WIDTH / 8,
  localparam int DEPTH = SIZE / NB,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_arbiter_if.slave     bus,
  output logic [AW-1:0]    ram_read_address,
  input  logic [WIDTH-1:0] ram_read_data,
  output logic             ram_write_en,
  output logic [AW-1:0]    ram_write_address,
  output logic [WIDTH-1:0] ram_write_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  ram_arb_state_t state;

  logic               last_grant;
  logic               owner_q;
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [NB-1:0]      wstrb_q;
  logic [WIDTH-1:0]   wr_data_q;
  logic [WIDTH-1:0]   merged;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic               resp_err_q;

  logic               grant;
  logic               any;
  logic [AW-1:0]      a_in;
  logic [NB-1:0]      s_in;
  logic               we_in;
  logic               err_in;
  logic               full_in;

  rr_grant2 u_grant (
    .valid (bus.req_valid),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  assign a_in    = bus.req_addr[grant];
  assign s_in    = bus.req_wstrb[grant];
  assign we_in   = bus.req_we[grant];
  assign err_in  = {1'b0, a_in} >= DEPTH_W;
  assign full_in = &s_in;

  assign bus.req_ready =
    (state == IDLE && any && reset_n) ? onehot(grant) : '0;

  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign merged[8*b +: 8] = wstrb_q[b] ?
      wdata_q[8*b +: 8] : ram_read_data[8*b +: 8];
  end

  // RAM read data only lands in DATA, so that path stays combinational
  assign bus.resp_rdata =
    (state == DATA && !we_q) ? ram_read_data : '0;
  assign ram_write_data =
    (state == DATA && we_q) ? merged : wr_data_q;

  assign ram_read_address = addr_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      owner_q           <= 1'b0;
      we_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      wr_data_q         <= '0;
      resp_valid_q      <= '0;
      resp_err_q        <= 1'b0;
      ram_write_en      <= 1'b0;
      ram_write_address <= '0;
    end else begin
      resp_valid_q      <= '0;
      resp_err_q        <= 1'b0;
      ram_write_en      <= 1'b0;
      ram_write_address <= '0;
      wr_data_q         <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            last_grant <= grant;
            owner_q    <= grant;
            we_q       <= we_in;
            addr_q     <= a_in;
            wdata_q    <= bus.req_wdata[grant];
            wstrb_q    <= s_in;
            if (err_in) begin
              state        <= WR;
              resp_valid_q <= onehot(grant);
              resp_err_q   <= 1'b1;
            end else if (!we_in || !full_in) begin
              state <= RD;
            end else begin
              state             <= WR;
              resp_valid_q      <= onehot(grant);
              ram_write_en      <= 1'b1;
              ram_write_address <= a_in;
              wr_data_q         <= bus.req_wdata[grant];
            end
          end
        end
        RD: begin
          state        <= DATA;
          resp_valid_q <= onehot(owner_q);
          if (we_q) begin
            ram_write_en      <= 1'b1;
            ram_write_address <= addr_q;
          end
        end
        DATA: state <= IDLE;
        WR:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for a single `block_ram` instance, using a round-robin grant. It sits between the instruction-fetch port (requester 0) and the load/store port (requester 1) of the core, and drives the RAM's separate read and write ports. It accepts one request at a time and returns a response pulse. Byte-masked stores are performed as read-modify-write, because the RAM has no byte enables.

## Interface
- `SIZE`, 4096: RAM size in bytes; must match the attached `block_ram`.
- `WIDTH`, 32: word width in bits; multiple of 8, at least 8.
- Derived: `NB = WIDTH/8`, `DEPTH = SIZE/NB`, `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock, all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active low. One clock; reset is asynchronous and active-low.
- `req_valid`  in  [1:0]  request valid, per requester.
- `req_ready`  out  [1:0]  request accepted this cycle, per requester.
- `req_we`  in  [1:0]  1 = write, 0 = read.
- `req_addr`  in  [1:0][AW-1:0]  word address.
- `req_wdata`  in  [1:0][WIDTH-1:0]  write data.
- `req_wstrb`  in  [1:0][NB-1:0]  byte strobes, used for writes only.
- `resp_valid`  out  [1:0]  one-cycle response pulse, per requester.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = address ≥ DEPTH.
- `resp_rdata`  out  WIDTH  read data; shared, qualified by `resp_valid`.
- `ram_read_address`  out  AW  to `block_ram.read_address`.
- `ram_read_data`  in  WIDTH  from `block_ram.read_data`.
- `ram_write_en`  out  1  to `block_ram.write_en`.
- `ram_write_address`  out  AW  to `block_ram.write_address`.
- `ram_write_data`  out  WIDTH  to `block_ram.write_data`.

The integrator drives `block_ram.reset` from `~reset_n`.

## Operation
- **FSM states:** IDLE, RD, DATA, WR.
- **IDLE:**
  - The grant is computed combinationally from `req_valid` and the `last_grant` register.
  - `req_ready[g]` is 1 for the granted requester only.
  - On handshake (`valid & ready`), the block latches owner, we, addr, wdata and wstrb, and updates `last_grant` to g.
- **Transitions out of IDLE (on handshake):**
  - `addr ≥ DEPTH` → WR, with the error flag set.
  - Read → RD.
  - Write with `wstrb` all ones → WR.
  - Write with any other `wstrb`, including all zeros → RD.
- **RD:** drives `ram_read_address = addr_q`, then → DATA.
- **DATA:** `ram_read_data` is valid in this state.
  - Read: pulse `resp_valid[owner]` with `resp_rdata = ram_read_data`, then → IDLE.
  - Partial write: compute `merged` per byte b as `wstrb_q[b] ? wdata_q[b] : ram_read_data[b]`. Assert `ram_write_en` with `merged`, pulse `resp_valid[owner]` (`resp_rdata = 0`), then → IDLE.
- **WR:**
  - Assert `ram_write_en` with `wdata_q` unless the error flag is set.
  - Pulse `resp_valid[owner]` with `resp_rdata = 0`; `resp_err` equals the error flag. Then → IDLE.
- **Round-robin:**
  - If both requesters are valid, grant goes to `~last_grant`.
  - If only one is valid, that one is granted.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **Requester rules:**
  - Requesters hold valid and all request fields stable until ready.
  - Responses have no backpressure.
- **Output values outside the active state:**
  - `ram_write_en` is 0 outside WR and partial-write DATA.
  - `ram_read_address` holds `addr_q`.
  - `ram_write_*` are registered; `ram_write_data` and `ram_write_address` are 0 when not writing.
- **Reset:**
  - IDLE; `last_grant = 1`.
  - All outputs 0: ready, resp_valid, resp_err, resp_rdata, ram_* (write_en, addresses, data).
  - Reset mid-transaction drops the transaction: no write, no response.

## Timing
- Handshake at cycle T.
- Read: response at T+2.
- Full write or error: `ram_write_en` and response at T+1; RAM updated at the end of T+1.
- Partial write: `ram_write_en` and response at T+2.
- Next handshake is possible in the response cycle + 1 at earliest. Peak throughput: one read per 3 cycles, one full write per 2 cycles.
- `req_ready` is never asserted outside IDLE, and never while `reset_n` = 0.
- No read/write hazard is possible: transactions are serialized.

## Structure
- Package `ram_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, RD, DATA, WR} ram_arb_state_t`
  - `localparam int NUM_REQ = 2`
- Sub-module `rr_grant2`: combinational 2-way round-robin picker. Inputs: valid[1:0], last. Outputs: grant index and any.
- The byte-merge is an inline generate loop over NB.

## Test plan
- Read, requester 0, addr 5, RAM[5] = 0xDEADBEEF → `resp_valid[0]` at T+2, `resp_rdata = 0xDEADBEEF`, `resp_err = 0`.
- Both requesters valid every cycle for 8 transactions → grants alternate 0,1,0,1…, with requester 0 first after reset.
- RAM[3] = 0x11223344, write wstrb = 0b0101, wdata = 0xAABBCCDD → RAM[3] = 0x11BB33DD, write at T+2; a following read returns 0x11BB33DD.
- Write wstrb = 0, addr 3 → ack at T+2, RAM[3] unchanged. Write wstrb = 0xF → `ram_write_en` at T+1, ack at T+1.
- SIZE = 3072 (DEPTH = 768), read addr 800 → `resp_err = 1`, `resp_rdata = 0`; no RAM write on a write to addr 800.
- `reset_n` low during DATA of a partial write → `ram_write_en` = 0 immediately, no `resp_valid`, FSM in IDLE, requester 0 granted first after release.
